// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: control FSM states, register-index width
// and the major opcodes used by decode and hazard logic.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } ctrl_state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use compare between the load in EX and the source registers in ID.
// Kept standalone so the forwarding-unit benches can reuse it.
module hazard_detect #(
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  loaduse
);

  // x0 is never a real producer, so a load to it cannot create a hazard.
  assign loaduse = ex_memread && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: load-use bubbles, taken-branch flushes, dmem freeze
// with timeout, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = riscv_pkg::REG_ADDR_W,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_branch_taken,
  input  logic                  mem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_flush,
  output logic                  pipe_hold,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  import riscv_pkg::*;

  localparam int REM_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [REM_W-1:0]  REM_LOAD  = REM_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state_reg, state_next;
  logic [REM_W-1:0]  rem_reg, rem_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;
  logic              loaduse, freeze, flush_evt;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .loaduse     (loaduse)
  );

  // Once waiting, only dmem_ready releases the freeze, even if mem_req drops.
  assign freeze = (state_reg == MEM_WAIT) ? !dmem_ready : (mem_req && !dmem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      rem_reg       <= '0;
      wait_reg      <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      wait_reg  <= wait_next;
      if (!pc_write && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_evt && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    wait_next  = wait_reg;
    flush_evt  = 1'b0;
    unique case (state_reg)
      RUN, MEM_WAIT: begin
        if (freeze) begin
          if (state_reg == RUN) begin
            state_next = MEM_WAIT;
            wait_next  = WAIT_W'(1);
          end else if (wait_reg == WAIT_LAST) begin
            state_next = ERR;
          end else begin
            wait_next = wait_reg + 1'b1;
          end
        end else begin
          state_next = RUN;
          if (mem_branch_taken) begin
            flush_evt = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = FLUSH;
              rem_next   = REM_LOAD;
            end
          end
        end
      end
      FLUSH: begin
        if (freeze) begin
          state_next = FLUSH;
        end else if (mem_branch_taken) begin
          flush_evt = 1'b1;
          rem_next  = REM_LOAD;
        end else begin
          rem_next = rem_reg - 1'b1;
          // The redirect cycle itself was the first flush, so leave as rem reaches 0.
          if (rem_reg == REM_W'(1)) state_next = RUN;
        end
      end
      ERR:     state_next = ERR;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    mem_timeout = 1'b0;
    if (state_reg == ERR || freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_hold   = 1'b1;
      mem_timeout = (state_reg == ERR);
    end else if (mem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (state_reg == FLUSH) begin
      ifid_flush = 1'b1;
    end else if (loaduse) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      pipe_hold   = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: table of single-cycle hazard vectors plus
// hand sequences for flush, memory wait, timeout and counter saturation.
module tb_pipeline_hazard_ctrl;
  localparam int FC = 3;
  localparam int MT = 8;
  localparam int CW = 4;

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, mem_timeout}
  localparam logic [6:0] NORM  = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0001000;
  localparam logic [6:0] BR    = 7'b1111100;
  localparam logic [6:0] FLSH  = 7'b1110000;
  localparam logic [6:0] HOLD  = 7'b0000010;
  localparam logic [6:0] ERRO  = 7'b0000011;
  localparam logic [6:0] ZERO  = 7'b0000000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs2 = 1'b0, ex_memread = 1'b0;
  logic          mem_branch_taken = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    outs;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, mem_timeout};

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       uses, memread;
    logic [4:0] rd;
    logic       br, req, rdy;
    logic [6:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  vec_t tbl[8];
  int   total = 0;
  int   bad   = 0;

  task automatic check_outs();
    sb_t e;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    total++;
    if (outs !== e.exp) begin
      bad++;
      $display("FAIL %s: outs=%b expected=%b", e.name, outs, e.exp);
    end else begin
      $display("ok   %s: outs=%b", e.name, outs);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end else begin
      $display("ok   %s: value=%0d", name, act);
    end
  endtask

  // Drives at posedge+1, checks at the following negedge, ends at next posedge+1.
  task automatic step_v(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.uses;
    ex_memread = v.memread; ex_rd = v.rd;
    mem_branch_taken = v.br; mem_req = v.req; dmem_ready = v.rdy;
    sb_q.push_back('{v.name, v.exp});
    #4;
    check_outs();
    @(posedge clk); #1;
  endtask

  // lu=1 presents a load-use hazard on rs1 (x5), otherwise unrelated registers.
  task automatic st(input string name, input logic br, req, rdy, lu, input logic [6:0] exp);
    vec_t v;
    v.name = name; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    v.uses = 1'b1;
    if (lu) begin
      v.rs1 = 5'd5; v.rs2 = 5'd2; v.memread = 1'b1; v.rd = 5'd5;
    end else begin
      v.rs1 = 5'd1; v.rs2 = 5'd2; v.memread = 1'b0; v.rd = 5'd3;
    end
    step_v(v);
  endtask

  task automatic apply_reset(input string name);
    rst = 1'b1;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 1'b1; ex_memread = 1'b0; ex_rd = 5'd3;
    mem_branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
    sb_q.push_back('{name, ZERO});
    #4;
    check_outs();
    check_val({name, "_stall_cnt"}, int'(stall_cnt), 0);
    check_val({name, "_flush_cnt"}, int'(flush_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{"lu_rs1",       5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, STALL};
    tbl[1] = '{"lu_rd0",       5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NORM};
    tbl[2] = '{"rs2_masked",   5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, NORM};
    tbl[3] = '{"rs2_used",     5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, STALL};
    tbl[4] = '{"no_load",      5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, NORM};
    tbl[5] = '{"no_match",     5'd3, 5'd6, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, NORM};
    tbl[6] = '{"mem_ready",    5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, NORM};
    tbl[7] = '{"mem_ready_lu", 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, STALL};

    apply_reset("reset");
    for (int i = 0; i < 8; i++) step_v(tbl[i]);
    check_val("table_stall_cnt", int'(stall_cnt), 3);

    apply_reset("reset_lu");
    st("lu_single", 1'b0, 1'b0, 1'b0, 1'b1, STALL);
    st("lu_cleared", 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    check_val("lu_stall_cnt", int'(stall_cnt), 1);

    apply_reset("reset_br");
    st("br_redirect", 1'b1, 1'b0, 1'b0, 1'b0, BR);
    check_val("br_flush_cnt", int'(flush_cnt), 1);
    st("br_flush2_lu_ignored", 1'b0, 1'b0, 1'b0, 1'b1, FLSH);
    st("br_flush3", 1'b0, 1'b0, 1'b0, 1'b0, FLSH);
    st("br_done", 1'b0, 1'b0, 1'b0, 0, NORM);
    st("br_lu_prio", 1'b1, 1'b0, 1'b0, 1'b1, BR);
    check_val("br_lu_stall_cnt", int'(stall_cnt), 0);
    check_val("br_lu_flush_cnt", int'(flush_cnt), 2);
    st("br_lu_flush2", 1'b0, 1'b0, 1'b0, 1'b0, FLSH);
    st("br_lu_flush3", 1'b0, 1'b0, 1'b0, 1'b0, FLSH);
    st("br_lu_done", 1'b0, 1'b0, 1'b0, 1'b0, NORM);

    apply_reset("reset_mw");
    for (int i = 0; i < 4; i++) st("mw_hold", 1'b0, 1'b1, 1'b0, 1'b0, HOLD);
    st("mw_release", 1'b0, 1'b1, 1'b1, 1'b0, NORM);
    check_val("mw_stall_cnt", int'(stall_cnt), 4);

    apply_reset("reset_mwb");
    st("mwb_hold1", 1'b1, 1'b1, 1'b0, 1'b0, HOLD);
    st("mwb_hold2", 1'b1, 1'b1, 1'b0, 1'b0, HOLD);
    check_val("mwb_flush_cnt_frozen", int'(flush_cnt), 0);
    st("mwb_release_flush", 1'b1, 1'b1, 1'b1, 1'b0, BR);
    check_val("mwb_flush_cnt", int'(flush_cnt), 1);

    apply_reset("reset_to");
    for (int i = 0; i < 8; i++) st("to_hold", 1'b0, 1'b1, 1'b0, 1'b0, HOLD);
    st("to_err", 1'b0, 1'b1, 1'b0, 1'b0, ERRO);
    st("to_sticky", 1'b0, 1'b0, 1'b1, 1'b0, ERRO);
    check_val("to_stall_cnt", int'(stall_cnt), 10);
    apply_reset("reset_from_err");
    st("after_err_reset", 1'b0, 1'b0, 1'b0, 1'b0, NORM);

    apply_reset("reset_sat");
    for (int i = 0; i < 20; i++) begin
      st("sat_lu", 1'b0, 1'b0, 1'b0, 1'b1, STALL);
      st("sat_gap", 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    end
    check_val("sat_stall_cnt", int'(stall_cnt), 15);
    for (int i = 0; i < 20; i++) st("sat_br", 1'b1, 1'b0, 1'b0, 1'b0, BR);
    check_val("sat_flush_cnt", int'(flush_cnt), 15);
    st("sat_flush2", 1'b0, 1'b0, 1'b0, 1'b0, FLSH);
    st("sat_flush3", 1'b0, 1'b0, 1'b0, 1'b0, FLSH);
    st("sat_done", 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    check_val("sat_stall_cnt_hold", int'(stall_cnt), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
